// File: rtl/agc_ones_alu_seq.sv
// agc_ones_alu_seq: multi-cycle ones'-complement AD/SU/MASK/CCS/MP sequencer with S2 overflow tracking.
// Define AGC_ALU_DV_EN to build the restoring divider for op 5; without it op 5 reports illegal.
module agc_ones_alu_seq #(
   parameter int WIDTH = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] l_in,
   input  logic [WIDTH-1:0] g_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] l_out,
   output logic             ovf,
   output logic             s2,
   output logic [1:0]       ccs_skip,
   output logic             illegal
);

   localparam int M  = WIDTH - 1;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]    CNT_LAST = CW'(M - 1);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

   localparam logic [2:0] OP_AD   = 3'd0;
   localparam logic [2:0] OP_SU   = 3'd1;
   localparam logic [2:0] OP_MASK = 3'd2;
   localparam logic [2:0] OP_CCS  = 3'd3;
   localparam logic [2:0] OP_MP   = 3'd4;
`ifdef AGC_ALU_DV_EN
   localparam logic [2:0] OP_DV   = 3'd5;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [M-1:0] mag(input logic [WIDTH-1:0] w);
      if (w[M]) begin
         mag = ~w[M-1:0];
      end else begin
         mag = w[M-1:0];
      end
   endfunction

   function automatic logic [WIDTH-1:0] signed_word(input logic sgn, input logic [M-1:0] m);
      if (sgn) begin
         signed_word = {1'b1, ~m};
      end else begin
         signed_word = {1'b0, m};
      end
   endfunction

   // Sign-extended add with end-around carry; bit WIDTH of the result is S2.
   function automatic logic [WIDTH:0] oc_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH+1:0] raw;
      raw    = {1'b0, x[M], x} + {1'b0, y[M], y};
      oc_add = raw[WIDTH:0] + {{WIDTH{1'b0}}, raw[WIDTH+1]};
   endfunction

   state_t           state_r, state_nx_s;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] a_r, g_r;
   logic [CW-1:0]    cnt_r;
   logic [M:0]       hi_r;
   logic [M-1:0]     lo_r, dvsr_r;
   logic             busy_r, done_r;
   logic [WIDTH-1:0] a_out_r, l_out_r;
   logic             ovf_r, s2_r, illegal_r;
   logic [1:0]       ccs_skip_r;

   logic [WIDTH:0]   sum_ad_s, sum_su_s;
   logic [M-1:0]     mag_a_s, mag_g_s;
   logic             sp_s, iter_op_s;
   logic [M:0]       mp_add_s, mp_hi_s, step_hi_s;
   logic [M-1:0]     mp_lo_s, step_lo_s;

   assign sum_ad_s = oc_add(a_r, g_r);
   assign sum_su_s = oc_add(a_r, ~g_r);
   assign mag_a_s  = mag(a_r);
   assign mag_g_s  = mag(g_r);
   assign sp_s     = a_r[M] ^ g_r[M];

   // Shift-add multiply: {hi,lo} is the 2M+1 bit partial product, multiplier consumed from lo.
   assign mp_add_s = hi_r + (lo_r[0] ? {1'b0, dvsr_r} : {(M+1){1'b0}});
   assign mp_hi_s  = {1'b0, mp_add_s[M:1]};
   assign mp_lo_s  = {mp_add_s[0], lo_r[M-1:1]};

`ifdef AGC_ALU_DV_EN
   logic [WIDTH-1:0] l_r;
   logic [M-1:0]     mag_l_s;
   logic             dv_ovf_s, dv_fit_s;
   logic [M:0]       dv_shift_s, dv_hi_s;
   logic [M-1:0]     dv_lo_s;

   assign mag_l_s    = mag(l_r);
   assign dv_ovf_s   = (mag_a_s >= mag_g_s);
   // Restoring step: {remainder,quotient} shifts left, trial subtract sets the quotient bit.
   assign dv_shift_s = {hi_r[M-1:0], lo_r[M-1]};
   assign dv_fit_s   = (dv_shift_s >= {1'b0, dvsr_r});
   assign dv_hi_s    = dv_fit_s ? (dv_shift_s - {1'b0, dvsr_r}) : dv_shift_s;
   assign dv_lo_s    = {lo_r[M-2:0], dv_fit_s};
   assign iter_op_s  = (op_r == OP_MP) || ((op_r == OP_DV) && !dv_ovf_s);
   assign step_hi_s  = (op_r == OP_MP) ? mp_hi_s : dv_hi_s;
   assign step_lo_s  = (op_r == OP_MP) ? mp_lo_s : dv_lo_s;
`else
   assign iter_op_s  = (op_r == OP_MP);
   assign step_hi_s  = mp_hi_s;
   assign step_lo_s  = mp_lo_s;
`endif

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = EXEC;
            end else begin
               state_nx_s = IDLE;
            end
         end
         EXEC: begin
            if (iter_op_s) begin
               state_nx_s = ITER;
            end else begin
               state_nx_s = DONE;
            end
         end
         ITER: begin
            if (cnt_r == CNT_LAST) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = ITER;
            end
         end
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // State register and registered handshake flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s != IDLE);
         done_r  <= (state_nx_s == DONE);
      end
   end

   // Operand capture, iteration registers and result writeback.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r       <= 3'd0;
         a_r        <= '0;
         g_r        <= '0;
`ifdef AGC_ALU_DV_EN
         l_r        <= '0;
`endif
         cnt_r      <= '0;
         hi_r       <= '0;
         lo_r       <= '0;
         dvsr_r     <= '0;
         a_out_r    <= '0;
         l_out_r    <= '0;
         ovf_r      <= 1'b0;
         s2_r       <= 1'b0;
         illegal_r  <= 1'b0;
         ccs_skip_r <= 2'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  op_r <= op;
                  a_r  <= a_in;
                  g_r  <= g_in;
`ifdef AGC_ALU_DV_EN
                  l_r  <= l_in;
`endif
               end
            end
            EXEC: begin
               cnt_r <= '0;
               case (op_r)
                  OP_AD: begin
                     a_out_r   <= {sum_ad_s[WIDTH], sum_ad_s[M-1:0]};
                     ovf_r     <= sum_ad_s[WIDTH] ^ sum_ad_s[M];
                     s2_r      <= sum_ad_s[WIDTH];
                     illegal_r <= 1'b0;
                  end
                  OP_SU: begin
                     a_out_r   <= {sum_su_s[WIDTH], sum_su_s[M-1:0]};
                     ovf_r     <= sum_su_s[WIDTH] ^ sum_su_s[M];
                     s2_r      <= sum_su_s[WIDTH];
                     illegal_r <= 1'b0;
                  end
                  OP_MASK: begin
                     a_out_r   <= a_r & g_r;
                     ovf_r     <= 1'b0;
                     s2_r      <= a_r[M] & g_r[M];
                     illegal_r <= 1'b0;
                  end
                  OP_CCS: begin
                     ovf_r     <= 1'b0;
                     s2_r      <= g_r[M];
                     illegal_r <= 1'b0;
                     if (g_r == '0) begin
                        a_out_r    <= '0;
                        ccs_skip_r <= 2'd1;
                     end else if (&g_r) begin
                        a_out_r    <= '0;
                        ccs_skip_r <= 2'd3;
                     end else if (g_r[M]) begin
                        a_out_r    <= ~g_r - W_ONE;
                        ccs_skip_r <= 2'd2;
                     end else begin
                        a_out_r    <= g_r - W_ONE;
                        ccs_skip_r <= 2'd0;
                     end
                  end
                  OP_MP: begin
                     hi_r   <= '0;
                     lo_r   <= mag_g_s;
                     dvsr_r <= mag_a_s;
                  end
`ifdef AGC_ALU_DV_EN
                  OP_DV: begin
                     if (dv_ovf_s) begin
                        a_out_r   <= {sp_s, {M{1'b1}}};
                        ovf_r     <= 1'b1;
                        s2_r      <= sp_s;
                        illegal_r <= 1'b0;
                     end else begin
                        hi_r   <= {1'b0, mag_a_s};
                        lo_r   <= mag_l_s;
                        dvsr_r <= mag_g_s;
                     end
                  end
`endif
                  default: illegal_r <= 1'b1;
               endcase
            end
            ITER: begin
               hi_r  <= step_hi_s;
               lo_r  <= step_lo_s;
               cnt_r <= cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  ovf_r     <= 1'b0;
                  s2_r      <= sp_s;
                  illegal_r <= 1'b0;
`ifdef AGC_ALU_DV_EN
                  if (op_r == OP_MP) begin
                     a_out_r <= signed_word(sp_s, step_hi_s[M-1:0]);
                     l_out_r <= signed_word(sp_s, step_lo_s);
                  end else begin
                     a_out_r <= signed_word(sp_s, step_lo_s);
                     l_out_r <= signed_word(a_r[M], step_hi_s[M-1:0]);
                  end
`else
                  a_out_r <= signed_word(sp_s, step_hi_s[M-1:0]);
                  l_out_r <= signed_word(sp_s, step_lo_s);
`endif
               end
            end
            DONE: begin
               cnt_r <= '0;
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign ready    = ~busy_r;
   assign done     = done_r;
   assign a_out    = a_out_r;
   assign l_out    = l_out_r;
   assign ovf      = ovf_r;
   assign s2       = s2_r;
   assign ccs_skip = ccs_skip_r;
   assign illegal  = illegal_r;

endmodule

// File: tb/tb_agc_ones_alu_seq.sv
// tb_agc_ones_alu_seq: directed vectors with hand-computed results for agc_ones_alu_seq at WIDTH=15.
module tb_agc_ones_alu_seq;

   localparam int W = 15;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a_in = '0, l_in = '0, g_in = '0;
   logic         ready, busy, done, ovf, s2, illegal;
   logic [W-1:0] a_out, l_out;
   logic [1:0]   ccs_skip;

   int checks = 0;
   int errors = 0;
   int lat, bcnt, ndone;

   logic [W-1:0] ccs_g   [5] = '{15'h0005, 15'h0000, 15'h7FFE, 15'h7FFF, 15'h7FF0};
   logic [W-1:0] ccs_a   [5] = '{15'h0004, 15'h0000, 15'h0000, 15'h0000, 15'h000E};
   logic [1:0]   ccs_k   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
   logic         ccs_s2  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   agc_ones_alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .a_in(a_in), .l_in(l_in), .g_in(g_in),
      .ready(ready), .busy(busy), .done(done),
      .a_out(a_out), .l_out(l_out), .ovf(ovf), .s2(s2),
      .ccs_skip(ccs_skip), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one op; lat = cycles from accept to done (0 if none), bcnt = busy cycles seen.
   task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] l,
                        input logic [W-1:0] g, input int poke);
      @(negedge clk);
      op = o; a_in = a; l_in = l; g_in = g; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      bcnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) bcnt++;
         if (done) begin
            lat = i;
            break;
         end
         if (i == poke) begin
            op = 3'd0; a_in = 15'h0001; l_in = 15'h0001; g_in = 15'h0001; start = 1'b1;
         end
      end
      start = 1'b0;
   endtask

   task automatic count_done(input int cycles);
      ndone = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_a", a_out, 0);
      check("rst_l", l_out, 0);
      check("rst_ovf", ovf, 0);
      check("rst_s2", s2, 0);
      check("rst_skip", ccs_skip, 0);
      check("rst_illegal", illegal, 0);

      do_op(3'd0, 15'h3FFF, 15'h0000, 15'h0001, 0);
      check("ad_ovf_lat", lat, 2);
      check("ad_ovf_busy", bcnt, 2);
      check("ad_ovf_a", a_out, 15'h0000);
      check("ad_ovf_ovf", ovf, 1);
      check("ad_ovf_s2", s2, 0);

      do_op(3'd1, 15'h0005, 15'h0000, 15'h0003, 0);
      check("su1_a", a_out, 15'h0002);
      check("su1_ovf", ovf, 0);
      check("su1_s2", s2, 0);

      do_op(3'd1, 15'h0003, 15'h0000, 15'h0005, 0);
      check("su2_a", a_out, 15'h7FFD);
      check("su2_ovf", ovf, 0);
      check("su2_s2", s2, 1);

      do_op(3'd0, 15'h0002, 15'h0000, 15'h7FFD, 0);
      check("ad_mz_a", a_out, 15'h7FFF);
      check("ad_mz_s2", s2, 1);

      do_op(3'd0, 15'h4000, 15'h0000, 15'h7FFE, 0);
      check("ad_nov_a", a_out, 15'h7FFF);
      check("ad_nov_ovf", ovf, 1);
      check("ad_nov_s2", s2, 1);

      do_op(3'd6, 15'h0001, 15'h0001, 15'h0001, 0);
      check("ill_lat", lat, 2);
      check("ill_flag", illegal, 1);
      check("ill_a", a_out, 15'h7FFF);
      check("ill_l", l_out, 15'h0000);
      check("ill_ovf", ovf, 1);

      do_op(3'd2, 15'h5A5A, 15'h0000, 15'h0FF0, 0);
      check("mask_a", a_out, 15'h0A50);
      check("mask_ovf", ovf, 0);
      check("mask_ill", illegal, 0);

      for (int i = 0; i < 5; i++) begin
         do_op(3'd3, 15'h0000, 15'h0000, ccs_g[i], 0);
         check($sformatf("ccs%0d_a", i), a_out, ccs_a[i]);
         check($sformatf("ccs%0d_skip", i), ccs_skip, ccs_k[i]);
         check($sformatf("ccs%0d_s2", i), s2, ccs_s2[i]);
      end

      do_op(3'd4, 15'h0003, 15'h0000, 15'h7FFB, 0);
      check("mp1_lat", lat, 16);
      check("mp1_busy", bcnt, 16);
      check("mp1_a", a_out, 15'h7FFF);
      check("mp1_l", l_out, 15'h7FF3);
      check("mp1_ovf", ovf, 0);
      check("mp1_s2", s2, 1);

      do_op(3'd4, 15'h3FFF, 15'h0000, 15'h3FFF, 0);
      check("mp2_a", a_out, 15'h3FFE);
      check("mp2_l", l_out, 15'h0001);
      check("mp2_s2", s2, 0);

      do_op(3'd4, 15'h7FFF, 15'h0000, 15'h0005, 0);
      check("mp3_a", a_out, 15'h7FFF);
      check("mp3_l", l_out, 15'h7FFF);
      check("mp3_s2", s2, 1);

`ifdef AGC_ALU_DV_EN
      do_op(3'd5, 15'h0001, 15'h0000, 15'h0001, 0);
      check("dvo_lat", lat, 2);
      check("dvo_ovf", ovf, 1);
      check("dvo_a", a_out, 15'h3FFF);
      check("dvo_l", l_out, 15'h7FFF);

      do_op(3'd5, 15'h0001, 15'h0000, 15'h2000, 0);
      check("dv_lat", lat, 16);
      check("dv_a", a_out, 15'h0002);
      check("dv_l", l_out, 15'h0000);
      check("dv_ovf", ovf, 0);
`else
      do_op(3'd5, 15'h0001, 15'h0000, 15'h0001, 0);
      check("dv_off_lat", lat, 2);
      check("dv_off_ill", illegal, 1);
      check("dv_off_a", a_out, 15'h7FFF);
      check("dv_off_l", l_out, 15'h7FFF);
`endif

      do_op(3'd4, 15'h0003, 15'h0000, 15'h7FFB, 3);
      check("busy_start_lat", lat, 16);
      check("busy_start_a", a_out, 15'h7FFF);
      check("busy_start_l", l_out, 15'h7FF3);
      count_done(5);
      check("busy_start_nodone", ndone, 0);
      check("busy_start_hold", a_out, 15'h7FFF);

      @(negedge clk);
      op = 3'd4; a_in = 15'h0003; l_in = 15'h0000; g_in = 15'h7FFB; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_a", a_out, 0);
      check("midrst_l", l_out, 0);
      @(negedge clk);
      reset = 1'b0;
      count_done(20);
      check("midrst_nodone", ndone, 0);
      check("midrst_idle", busy, 0);

      do_op(3'd0, 15'h0005, 15'h0000, 15'h0003, 0);
      check("post_rst_lat", lat, 2);
      check("post_rst_a", a_out, 15'h0008);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
